// File: rtl/apb_irq_router_pkg.sv
// Shared types and register map for the APB interrupt router.
package apb_irq_router_pkg;

  localparam logic [31:0] IRQR_MODE_OFF   = 32'h0000_0000;
  localparam logic [31:0] IRQR_PEND_OFF   = 32'h0000_0400;
  localparam logic [31:0] IRQR_ENA_OFF    = 32'h0000_0800;
  localparam logic [31:0] IRQR_INFO_OFF   = 32'h0000_0FFC;
  localparam logic [31:0] IRQR_CTX_STRIDE = 32'h0000_0080;

  localparam logic [15:0] IRQR_VENDOR_ID = 16'h00F1;
  localparam logic [15:0] IRQR_DEVICE_ID = 16'h0A71;

  typedef struct packed {
    logic [31:0] addr_start;
    logic [31:0] addr_end;
  } mapinfo_type;

  typedef struct packed {
    logic [15:0] vid;
    logic [15:0] did;
    logic [31:0] addr_start;
    logic [31:0] addr_end;
  } dev_config_type;

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;

  typedef enum logic [2:0] {
    BANK_NONE, BANK_MODE, BANK_PEND, BANK_ENA, BANK_INFO
  } irqr_bank_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } irqr_state_e;

endpackage

// File: rtl/apb_irq_router_if.sv
// APB request/response bundle between bus1 and the interrupt router.
interface apb_irq_router_if;
  apb_irq_router_pkg::apb_in_type  i_apbi;
  apb_irq_router_pkg::apb_out_type o_apbo;

  modport master (output i_apbi, input o_apbo);
  modport slave  (input i_apbi, output o_apbo);
endinterface

// File: rtl/apb_irq_router_src_sync.sv
// One interrupt source: synchroniser, history flop and edge/level pending bit.
module irq_src_sync #(
  parameter int sync_stages = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  input  logic i_mode,
  input  logic i_w1c,
  output logic o_pending
);
  logic [sync_stages-1:0] sync_q, sync_d;
  logic hist_q, hist_d;
  logic pend_q, pend_d;
  logic s;

  assign s = sync_q[sync_stages-1];

  always_comb begin
    sync_d    = '0;
    sync_d[0] = i_irq;
    for (int i = 1; i < sync_stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = s;
    // A fresh edge beats a same-cycle clear so no interrupt is lost.
    pend_d = i_mode ? ((pend_q & ~i_w1c) | (s & ~hist_q)) : s;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      pend_q <= pend_d;
    end
  end

  assign o_pending = pend_q;
endmodule

// File: rtl/apb_irq_router.sv
// Run-time configurable interrupt router: per-source sync/latch, per-context
// enable masks and an APB register window.
module apb_irq_router
  import apb_irq_router_pkg::*;
#(
  parameter int src_num     = 64,
  parameter int ctx_num     = 8,
  parameter int sync_stages = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  mapinfo_type          i_mapinfo,
  output dev_config_type       o_cfg,
  apb_irq_router_if.slave      apb,
  input  logic [src_num-1:0]   i_irq,
  output logic [ctx_num-1:0]   o_ip
);
  localparam int WORDS = src_num / 32;
  localparam logic [31:0] INFO_WORD = {4'h0, 4'(sync_stages), 8'(ctx_num), 16'(src_num)};

  irqr_state_e state_q, state_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [src_num-1:0] mode_q, mode_d;
  logic [src_num-1:0] w1c;
  logic [src_num-1:0] pending;
  logic [ctx_num-1:0][src_num-1:0] enable_q, enable_d;
  logic [ctx_num-1:0] ip_q, ip_d;

  logic [31:0] off;
  logic [29:0] ena_word;
  irqr_bank_e  bank;
  int          w_idx, c_idx;
  logic [3:0]  unused_bits;

  assign pending[0] = 1'b0;

  for (genvar gi = 1; gi < src_num; gi++) begin : g_src
    irq_src_sync #(.sync_stages(sync_stages)) u_src (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_irq     (i_irq[gi]),
      .i_mode    (mode_q[gi]),
      .i_w1c     (w1c[gi]),
      .o_pending (pending[gi])
    );
  end

  // INFO is tested first so it shadows any ENABLE slot that would alias 0xFFC.
  always_comb begin
    off      = apb.i_apbi.paddr - i_mapinfo.addr_start;
    ena_word = off[31:2] - IRQR_ENA_OFF[31:2];
    bank     = BANK_NONE;
    w_idx    = 0;
    c_idx    = 0;
    if (off[31:2] == IRQR_INFO_OFF[31:2]) begin
      bank = BANK_INFO;
    end else if (off[31:10] == IRQR_MODE_OFF[31:10]) begin
      if (int'(off[9:2]) < WORDS) begin
        bank  = BANK_MODE;
        w_idx = int'(off[9:2]);
      end
    end else if (off[31:10] == IRQR_PEND_OFF[31:10]) begin
      if (int'(off[9:2]) < WORDS) begin
        bank  = BANK_PEND;
        w_idx = int'(off[9:2]);
      end
    end else if (off[31:2] >= IRQR_ENA_OFF[31:2]) begin
      if (int'(ena_word[29:5]) < ctx_num && int'(ena_word[4:0]) < WORDS) begin
        bank  = BANK_ENA;
        c_idx = int'(ena_word[29:5]);
        w_idx = int'(ena_word[4:0]);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mode_d    = mode_q;
    enable_d  = enable_q;
    w1c       = '0;
    ip_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (apb.i_apbi.psel && apb.i_apbi.penable) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
          if (bank == BANK_NONE) begin
            pslverr_d = 1'b1;
          end else if (apb.i_apbi.pwrite) begin
            case (bank)
              BANK_MODE: mode_d[w_idx*32 +: 32] = apb.i_apbi.pwdata;
              BANK_PEND: w1c[w_idx*32 +: 32] = apb.i_apbi.pwdata;
              BANK_ENA:  enable_d[c_idx][w_idx*32 +: 32] = apb.i_apbi.pwdata;
              default:   ;
            endcase
          end else begin
            case (bank)
              BANK_MODE: prdata_d = mode_q[w_idx*32 +: 32];
              BANK_PEND: prdata_d = pending[w_idx*32 +: 32];
              BANK_ENA:  prdata_d = enable_q[c_idx][w_idx*32 +: 32];
              BANK_INFO: prdata_d = INFO_WORD;
              default:   ;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mode_d[0] = 1'b0;
    for (int c = 0; c < ctx_num; c++) begin
      enable_d[c][0] = 1'b0;
      ip_d[c]        = |(pending & enable_q[c]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      mode_q    <= '0;
      enable_q  <= '0;
      ip_q      <= '0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      mode_q    <= mode_d;
      enable_q  <= enable_d;
      ip_q      <= ip_d;
    end
  end

  assign unused_bits = {off[1:0], w1c[0], i_irq[0]};
  assign apb.o_apbo  = {prdata_q, pready_q, pslverr_q};
  assign o_ip        = ip_q;
  assign o_cfg       = '{vid: IRQR_VENDOR_ID, did: IRQR_DEVICE_ID,
                         addr_start: i_mapinfo.addr_start, addr_end: i_mapinfo.addr_end};
endmodule
